// File: rtl/imc_op_scheduler.sv
`timescale 1ns/1ps
// imc_op_scheduler
// Shares one SRAM/IMC controller between a host memory port and an IMC job
// engine. One controller transaction is in flight at a time; completion is
// tracked through ctrl_halt and reported with single-cycle done pulses.
//
// Optional feature (macro IMC_SCHED_WDOG_EN): launch watchdog. A request
// that sees no ctrl_halt within TIMEOUT launch cycles is dropped and
// sched_err latches high until reset. Without the macro sched_err is 0.
//
// Ports
//   clk, reset            clock (posedge), async active-low reset
//   host_req/rw/addr      host single-row request (level, held until gnt)
//   host_gnt, host_done   1-cycle pulses: accepted / finished
//   imc_start/num_vec     start an IMC job of imc_num_vec vector cycles
//   imc_busy, imc_done    job in progress / last vector finished (pulse)
//   vec_left              vectors remaining in current job
//   ctrl_*                request outputs to the controller; all registered
//   ctrl_halt             controller busy indication (1 while op runs)
//   sched_err             sticky watchdog error
module imc_op_scheduler #(
  parameter int NVEC_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_req,
  input  logic              host_rw,
  input  logic [3:0]        host_addr,
  output logic              host_gnt,
  output logic              host_done,
  input  logic              imc_start,
  input  logic [NVEC_W-1:0] imc_num_vec,
  output logic              imc_busy,
  output logic              imc_done,
  output logic [NVEC_W-1:0] vec_left,
  output logic              ctrl_rw,
  output logic [3:0]        ctrl_addr,
  output logic              ctrl_en_dec,
  output logic              ctrl_mem_en,
  output logic              ctrl_imc_en,
  input  logic              ctrl_halt,
  output logic              sched_err
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_GAP} state_t;

  state_t            state_q, state_d;
  logic              own_imc_q, own_imc_d;    // owner of the op in flight
  logic              last_imc_q, last_imc_d;  // last completed grant was IMC
  logic              host_gnt_q, host_gnt_d;
  logic              host_done_q, host_done_d;
  logic              imc_busy_q, imc_busy_d;
  logic              imc_done_q, imc_done_d;
  logic [NVEC_W-1:0] vec_left_q, vec_left_d;
  logic              ctrl_rw_q, ctrl_rw_d;
  logic [3:0]        ctrl_addr_q, ctrl_addr_d;
  logic              ctrl_en_dec_q, ctrl_en_dec_d;
  logic              ctrl_mem_en_q, ctrl_mem_en_d;
  logic              ctrl_imc_en_q, ctrl_imc_en_d;
  logic              imc_pend;
`ifdef IMC_SCHED_WDOG_EN
  logic [15:0]       wdog_cnt_q, wdog_cnt_d;
  logic              err_q, err_d;
`endif

  always_comb begin
    state_d       = state_q;
    own_imc_d     = own_imc_q;
    last_imc_d    = last_imc_q;
    host_gnt_d    = 1'b0;
    host_done_d   = 1'b0;
    imc_done_d    = 1'b0;
    imc_busy_d    = imc_busy_q;
    vec_left_d    = vec_left_q;
    ctrl_rw_d     = ctrl_rw_q;
    ctrl_addr_d   = ctrl_addr_q;
    ctrl_en_dec_d = ctrl_en_dec_q;
    ctrl_mem_en_d = ctrl_mem_en_q;
    ctrl_imc_en_d = ctrl_imc_en_q;
`ifdef IMC_SCHED_WDOG_EN
    wdog_cnt_d    = wdog_cnt_q;
    err_d         = err_q;
`endif
    imc_pend      = imc_busy_q && (vec_left_q != '0);

    // Job acceptance; an empty job completes immediately without a launch.
    if (imc_start && !imc_busy_q) begin
      if (imc_num_vec == '0) begin
        imc_done_d = 1'b1;
      end else begin
        imc_busy_d = 1'b1;
        vec_left_d = imc_num_vec;
      end
    end

    case (state_q)
      S_IDLE: begin
        // Round-robin on contention: host wins unless it was granted last.
        if (host_req && (!imc_pend || last_imc_q)) begin
          host_gnt_d    = 1'b1;
          own_imc_d     = 1'b0;
          ctrl_mem_en_d = 1'b1;
          ctrl_en_dec_d = 1'b1;
          ctrl_rw_d     = host_rw;
          ctrl_addr_d   = host_addr;
          state_d       = S_LAUNCH;
        end else if (imc_pend) begin
          own_imc_d     = 1'b1;
          ctrl_imc_en_d = 1'b1;
          ctrl_en_dec_d = 1'b0;
          ctrl_rw_d     = 1'b1;
          state_d       = S_LAUNCH;
        end
`ifdef IMC_SCHED_WDOG_EN
        wdog_cnt_d = '0;
`endif
      end
      S_LAUNCH: begin
        if (ctrl_halt) begin
          state_d = S_RUN;
        end
`ifdef IMC_SCHED_WDOG_EN
        else begin
          wdog_cnt_d = wdog_cnt_q + 16'd1;
          // This is the TIMEOUT-th launch cycle without a halt: give up.
          if (wdog_cnt_q == 16'(TIMEOUT - 1)) begin
            err_d         = 1'b1;
            ctrl_mem_en_d = 1'b0;
            ctrl_imc_en_d = 1'b0;
            ctrl_en_dec_d = 1'b0;
            ctrl_rw_d     = 1'b1;
            if (own_imc_q) begin
              imc_busy_d = 1'b0;
              vec_left_d = '0;
            end
            state_d = S_IDLE;
          end
        end
`endif
      end
      S_RUN: begin
        // Completion effects are registered so they show during S_GAP.
        if (!ctrl_halt) begin
          ctrl_mem_en_d = 1'b0;
          ctrl_imc_en_d = 1'b0;
          ctrl_en_dec_d = 1'b0;
          ctrl_rw_d     = 1'b1;
          if (own_imc_q) begin
            vec_left_d = vec_left_q - 1'b1;
            if (vec_left_q == NVEC_W'(1)) begin
              imc_done_d = 1'b1;
              imc_busy_d = 1'b0;
            end
          end else begin
            host_done_d = 1'b1;
          end
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        last_imc_d = own_imc_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      own_imc_q     <= 1'b0;
      last_imc_q    <= 1'b1;
      host_gnt_q    <= 1'b0;
      host_done_q   <= 1'b0;
      imc_busy_q    <= 1'b0;
      imc_done_q    <= 1'b0;
      vec_left_q    <= '0;
      ctrl_rw_q     <= 1'b1;
      ctrl_addr_q   <= '0;
      ctrl_en_dec_q <= 1'b0;
      ctrl_mem_en_q <= 1'b0;
      ctrl_imc_en_q <= 1'b0;
`ifdef IMC_SCHED_WDOG_EN
      wdog_cnt_q    <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      own_imc_q     <= own_imc_d;
      last_imc_q    <= last_imc_d;
      host_gnt_q    <= host_gnt_d;
      host_done_q   <= host_done_d;
      imc_busy_q    <= imc_busy_d;
      imc_done_q    <= imc_done_d;
      vec_left_q    <= vec_left_d;
      ctrl_rw_q     <= ctrl_rw_d;
      ctrl_addr_q   <= ctrl_addr_d;
      ctrl_en_dec_q <= ctrl_en_dec_d;
      ctrl_mem_en_q <= ctrl_mem_en_d;
      ctrl_imc_en_q <= ctrl_imc_en_d;
`ifdef IMC_SCHED_WDOG_EN
      wdog_cnt_q    <= wdog_cnt_d;
      err_q         <= err_d;
`endif
    end
  end

  assign host_gnt    = host_gnt_q;
  assign host_done   = host_done_q;
  assign imc_busy    = imc_busy_q;
  assign imc_done    = imc_done_q;
  assign vec_left    = vec_left_q;
  assign ctrl_rw     = ctrl_rw_q;
  assign ctrl_addr   = ctrl_addr_q;
  assign ctrl_en_dec = ctrl_en_dec_q;
  assign ctrl_mem_en = ctrl_mem_en_q;
  assign ctrl_imc_en = ctrl_imc_en_q;

`ifdef IMC_SCHED_WDOG_EN
  assign sched_err = err_q;
`else
  // TIMEOUT only has meaning with the watchdog present.
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT);
  assign sched_err      = 1'b0;
`endif

endmodule

// File: tb/tb_imc_op_scheduler.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for imc_op_scheduler. A small controller model
// answers launches with ctrl_halt; a transaction-level arbitration model
// predicts the launch order, which a negedge monitor checks.
module tb_imc_op_scheduler;

`ifdef IMC_SCHED_WDOG_EN
  localparam int WDOG_TO = 8;
`else
  localparam int WDOG_TO = 64;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       host_req, host_rw;
  logic [3:0] host_addr;
  logic       host_gnt, host_done;
  logic       imc_start;
  logic [7:0] imc_num_vec;
  logic       imc_busy, imc_done;
  logic [7:0] vec_left;
  logic       ctrl_rw, ctrl_en_dec, ctrl_mem_en, ctrl_imc_en, ctrl_halt, sched_err;
  logic [3:0] ctrl_addr;

  imc_op_scheduler #(.NVEC_W(8), .TIMEOUT(WDOG_TO)) dut (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_rw(host_rw), .host_addr(host_addr),
    .host_gnt(host_gnt), .host_done(host_done),
    .imc_start(imc_start), .imc_num_vec(imc_num_vec),
    .imc_busy(imc_busy), .imc_done(imc_done), .vec_left(vec_left),
    .ctrl_rw(ctrl_rw), .ctrl_addr(ctrl_addr), .ctrl_en_dec(ctrl_en_dec),
    .ctrl_mem_en(ctrl_mem_en), .ctrl_imc_en(ctrl_imc_en),
    .ctrl_halt(ctrl_halt), .sched_err(sched_err)
  );

  always #5 clk = ~clk;

  typedef struct {bit imc; bit rw; logic [3:0] addr; logic [7:0] vl;} op_t;

  op_t exp_q[$];   // expected launches, in order
  op_t host_q[$];  // host driver work list
  op_t plan_h[$];  // host ops of the next scenario
  int  exp_hd, exp_id;
  int  checks, errors;
  int  en_cycles, hd_seen;
  int  fix_d, fix_h;
  bit  ctl_on, sb_off, m_last_imc;
  bit  en_prev, gnt_prev;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Controller model: after a launch, raise halt d cycles later, hold h cycles.
  initial begin
    int d, h;
    ctrl_halt = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset && ctl_on && (ctrl_mem_en || ctrl_imc_en) && !ctrl_halt) begin
        d = (fix_d >= 0) ? fix_d : int'($urandom_range(0, 3));
        h = (fix_h > 0)  ? fix_h : int'($urandom_range(1, 5));
        repeat (d) @(posedge clk);
        #1 ctrl_halt = 1'b1;
        repeat (h) @(posedge clk);
        #1 ctrl_halt = 1'b0;
      end
    end
  end

  // Host driver: keeps host_req high while work is queued, advances on gnt.
  initial begin
    host_req = 1'b0; host_rw = 1'b1; host_addr = 4'd0;
    forever begin
      @(posedge clk); #2;
      if (!reset) begin
        host_req = 1'b0;
        host_q.delete();
      end else begin
        if (host_req && host_gnt) void'(host_q.pop_front());
        if (host_q.size() > 0) begin
          host_req = 1'b1; host_rw = host_q[0].rw; host_addr = host_q[0].addr;
        end else host_req = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    bit  en_now;
    op_t e;
    en_now = ctrl_mem_en | ctrl_imc_en;
    if (reset) begin
      if (en_now) en_cycles++;
      if (host_done) hd_seen++;
    end
    if (reset && !sb_off) begin
      if (en_now) chk(!(ctrl_mem_en && ctrl_imc_en), "both_enables", 2, 1);
      if (en_now && !en_prev) begin
        if (exp_q.size() == 0) chk(1'b0, "unexpected_launch", ctrl_imc_en, 0);
        else begin
          e = exp_q.pop_front();
          chk(ctrl_imc_en == e.imc, "launch_kind", ctrl_imc_en, e.imc);
          if (e.imc) begin
            chk(!ctrl_en_dec && ctrl_rw, "imc_ctrl", {ctrl_en_dec, ctrl_rw}, 1);
            chk(vec_left == e.vl, "imc_vec_left", vec_left, e.vl);
          end else begin
            chk(host_gnt && ctrl_en_dec, "host_gnt_dec", {host_gnt, ctrl_en_dec}, 3);
            chk(ctrl_rw == e.rw, "host_rw", ctrl_rw, e.rw);
            chk(ctrl_addr == e.addr, "host_addr", ctrl_addr, e.addr);
          end
        end
      end
      if (host_gnt) chk(!gnt_prev, "gnt_width", 2, 1);
      if (host_done) begin
        chk(exp_hd > 0, "host_done_unexpected", 1, exp_hd);
        if (exp_hd > 0) exp_hd--;
        chk(!en_now, "gap_enables", en_now, 0);
      end
      if (imc_done) begin
        chk(exp_id > 0, "imc_done_unexpected", 1, exp_id);
        if (exp_id > 0) exp_id--;
        chk(!imc_busy && vec_left == 0, "imc_done_state", {imc_busy, vec_left}, 0);
      end
      chk(sched_err == 1'b0, "sched_err", sched_err, 0);
    end
    en_prev  = en_now;
    gnt_prev = host_gnt;
  end

  task automatic check_reset_vals(input string tag);
    chk({host_gnt, host_done, imc_busy, imc_done, ctrl_en_dec, ctrl_mem_en, ctrl_imc_en, sched_err} == 8'd0,
        {tag, "_flags"}, {host_gnt, host_done, imc_busy, imc_done, ctrl_en_dec, ctrl_mem_en, ctrl_imc_en, sched_err}, 0);
    chk(vec_left == 8'd0, {tag, "_vec_left"}, vec_left, 0);
    chk(ctrl_rw == 1'b1 && ctrl_addr == 4'd0, {tag, "_rw_addr"}, {ctrl_rw, ctrl_addr}, 16);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 3000 && (exp_q.size() != 0 || exp_hd != 0 || exp_id != 0 || host_q.size() != 0 ||
                        imc_busy || ctrl_mem_en || ctrl_imc_en)) begin
      @(negedge clk); n++;
    end
    chk(n < 3000, "drain_timeout", n, 3000);
    if (n >= 3000) begin exp_q.delete(); exp_hd = 0; exp_id = 0; end
    repeat (3) @(negedge clk);
  endtask

  // nv < 0: no IMC job. poke: pulse imc_start while the job is busy.
  task automatic run_mix(input int nv, input bit poke);
    int h, v, nh, n;
    op_t o;
    logic [7:0] vl;
    nh = plan_h.size(); h = 0; v = (nv < 0) ? 0 : nv;
    if (nv == 0) exp_id++;
    while (h < nh || v > 0) begin
      if (h < nh && (v == 0 || m_last_imc)) begin
        exp_q.push_back(plan_h[h]); exp_hd++; h++; m_last_imc = 1'b0;
      end else begin
        o.imc = 1'b1; o.rw = 1'b1; o.addr = 4'd0; o.vl = 8'(v);
        exp_q.push_back(o);
        if (v == 1) exp_id++;
        v--; m_last_imc = 1'b1;
      end
    end
    @(negedge clk);
    foreach (plan_h[i]) host_q.push_back(plan_h[i]);
    if (nv >= 0) begin imc_start = 1'b1; imc_num_vec = 8'(nv); end
    @(negedge clk);
    imc_start = 1'b0;
    if (nv == 0) chk(imc_done && !imc_busy, "zero_vec_done", {imc_done, imc_busy}, 2);
    else if (nv > 0) chk(imc_busy && vec_left == 8'(nv), "job_accept", vec_left, nv);
    if (poke) begin
      n = 0;
      while (!ctrl_imc_en && n < 50) begin @(negedge clk); n++; end
      chk(n < 50, "poke_wait", n, 50);
      vl = vec_left;
      imc_start = 1'b1; imc_num_vec = 8'd7;
      @(negedge clk);
      imc_start = 1'b0;
      chk(vec_left == vl, "start_while_busy", vec_left, vl);
    end
    plan_h.delete();
    wait_idle();
  endtask

  task automatic add_host(input bit rw, input logic [3:0] a);
    op_t o;
    o.imc = 1'b0; o.rw = rw; o.addr = a; o.vl = 8'd0;
    plan_h.push_back(o);
  endtask

  initial begin
    int n;
    reset = 1'b0; imc_start = 1'b0; imc_num_vec = 8'd0;
    checks = 0; errors = 0; exp_hd = 0; exp_id = 0; en_cycles = 0; hd_seen = 0;
    fix_d = -1; fix_h = 0; ctl_on = 1'b1; sb_off = 1'b0; m_last_imc = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single host write, fixed halt timing: enables span launch + halt window.
    fix_d = 2; fix_h = 5; en_cycles = 0; hd_seen = 0;
    add_host(1'b0, 4'd5);
    run_mix(-1, 1'b0);
    chk(en_cycles == 8, "host_en_span", en_cycles, 8);
    chk(hd_seen == 1, "host_done_count", hd_seen, 1);
    fix_d = -1; fix_h = 0;

    // Three-vector job plus an ignored restart while busy.
    run_mix(3, 1'b1);
    // Host contention during a four-vector job: grants alternate.
    add_host(1'b1, 4'd9); add_host(1'b0, 4'd3); add_host(1'b1, 4'd12);
    run_mix(4, 1'b0);
    // Empty job.
    run_mix(0, 1'b0);

    // Reset while the controller is running an IMC op.
    fix_d = 0; fix_h = 12;
    exp_q.push_back('{imc: 1'b1, rw: 1'b1, addr: 4'd0, vl: 8'd2});
    @(negedge clk); imc_start = 1'b1; imc_num_vec = 8'd2;
    @(negedge clk); imc_start = 1'b0;
    n = 0;
    while (!ctrl_imc_en && n < 50) begin @(negedge clk); n++; end
    chk(n < 50, "run_wait", n, 50);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 check_reset_vals("midrun");
    exp_q.delete(); exp_hd = 0; exp_id = 0; m_last_imc = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk(!imc_busy && vec_left == 0, "post_reset_idle", {imc_busy, vec_left}, 0);
    fix_d = -1; fix_h = 0;

    // Randomized mixes.
    for (int it = 0; it < 12; it++) begin
      int nh;
      nh = int'($urandom_range(0, 4));
      for (int k = 0; k < nh; k++) add_host(1'($urandom), 4'($urandom));
      run_mix(int'($urandom_range(0, 5)), 1'b0);
    end

`ifdef IMC_SCHED_WDOG_EN
    // Halt never rises: request dropped after TIMEOUT launch cycles.
    sb_off = 1'b1; ctl_on = 1'b0; en_cycles = 0; hd_seen = 0;
    add_host(1'b1, 4'd7);
    foreach (plan_h[i]) host_q.push_back(plan_h[i]);
    plan_h.delete();
    repeat (40) @(negedge clk);
    chk(en_cycles == WDOG_TO, "wdog_launch_cycles", en_cycles, WDOG_TO);
    chk(sched_err == 1'b1, "wdog_err", sched_err, 1);
    chk(hd_seen == 0, "wdog_no_done", hd_seen, 0);
    chk(!ctrl_mem_en && !ctrl_imc_en, "wdog_enables", {ctrl_mem_en, ctrl_imc_en}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; ctl_on = 1'b1; sb_off = 1'b0; m_last_imc = 1'b1;
    repeat (2) @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
